// File: rtl/eth_pkg.sv
// eth_pkg: shared CRC constants, dibit/slot types and a dibit CRC step helper
package eth_pkg;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  typedef logic [1:0] dibit_t;
  typedef logic [1:0] slot_t;
  // d[0] goes in first, matching wire order
  function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input dibit_t d, input logic [31:0] poly);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? poly : 32'h0);
    return c;
  endfunction
endpackage

// File: rtl/dibit_crc32_path_if.sv
// dibit_crc32_path_if: dibit input stream plus re-ordered and CRC output streams
interface dibit_crc32_path_if;
  import eth_pkg::*;
  logic axiiv;
  dibit_t axiid;
  logic order_axiov;
  dibit_t order_axiod;
  logic crc_axiov;
  logic [31:0] crc_axiod;
  modport master(output axiiv, axiid, input order_axiov, order_axiod, crc_axiov, crc_axiod);
  modport slave(input axiiv, axiid, output order_axiov, order_axiod, crc_axiov, crc_axiod);
endinterface

// File: rtl/dibit_reverser.sv
// dibit_reverser: ping-pong byte buffer turning MS-dibit-first bytes into LS-dibit-first
module dibit_reverser
  import eth_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_v,
  input  dibit_t in_d,
  output logic   out_v,
  output dibit_t out_d
);
  slot_t cnt_in, cnt_out;
  dibit_t cap [3];
  dibit_t hold [3];
  // slot 3 is emitted straight from the input, so only slots 0..2 are buffered
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_in <= '0;
      cnt_out <= '0;
      out_v <= 1'b0;
      out_d <= '0;
      cap <= '{default: '0};
      hold <= '{default: '0};
    end else begin
      if (in_v) cnt_in <= cnt_in + 2'd1;
      if (in_v && cnt_in != 2'd3) cap[cnt_in] <= in_d;
      if (in_v && cnt_in == 2'd3) begin
        hold <= cap;
        cnt_out <= 2'd3;
        out_v <= 1'b1;
        out_d <= in_d;
      end else if (cnt_out != 2'd0) begin
        cnt_out <= cnt_out - 2'd1;
        out_v <= 1'b1;
        out_d <= hold[cnt_out - 2'd1];
      end else begin
        out_v <= 1'b0;
        out_d <= '0;
      end
    end
  end
endmodule

// File: rtl/dibit_crc32_path.sv
// dibit_crc32_path: RMII TX dibit re-order plus CRC-32 over the wire-order stream
module dibit_crc32_path
  import eth_pkg::*;
#(
  parameter logic [31:0] POLY = CRC_POLY,
  parameter logic [31:0] INIT = CRC_INIT
) (
  input logic clk,
  input logic rst,
  dibit_crc32_path_if.slave bus
);
  logic ov, crc_v;
  dibit_t od;
  logic [31:0] crc, c;
  dibit_reverser u_rev (.clk(clk), .rst(rst), .in_v(bus.axiiv), .in_d(bus.axiid), .out_v(ov), .out_d(od));
  always_ff @(posedge clk) begin
    if (!rst) begin
      crc <= INIT;
      crc_v <= 1'b0;
    end else begin
      crc_v <= ov;
      if (ov) crc <= crc_dibit(crc, od, POLY);
    end
  end
  assign c = ~crc;
  // pair swap so that dibit k=15 puts ~crc[31] on txd[0]
  always_comb begin
    bus.crc_axiod = '0;
    for (int k = 0; k < 16; k++) begin
      bus.crc_axiod[2*k+1] = c[2*k];
      bus.crc_axiod[2*k] = c[2*k+1];
    end
  end
  assign bus.order_axiov = ov;
  assign bus.order_axiod = od;
  assign bus.crc_axiov = crc_v;
endmodule

// File: tb/tb_dibit_crc32_path.sv
// tb_dibit_crc32_path: randomized and directed checks against a byte-level reference model
module tb_dibit_crc32_path;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  int nz = 0;
  bit collect = 1'b0;
  logic [1:0] got[$];
  logic [7:0] check_str[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  dibit_crc32_path_if bus();
  dibit_crc32_path dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (collect) begin
      if (bus.order_axiov) got.push_back(bus.order_axiod);
      else if (bus.order_axiod !== 2'b00) nz++;
    end

  // standard reflected Ethernet CRC-32 over bytes
  function automatic logic [31:0] std_crc(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c ^= {24'h0, q[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // bit-reverse the standard FCS, then swap each bit pair for dibit transmit layout
  function automatic logic [31:0] wire_fcs(input logic [31:0] s);
    logic [31:0] r, w;
    for (int i = 0; i < 32; i++) r[i] = s[31-i];
    for (int k = 0; k < 16; k++) begin
      w[2*k+1] = r[2*k];
      w[2*k] = r[2*k+1];
    end
    return w;
  endfunction

  function automatic logic [1:0] dib(input logic [7:0] b, input int k);
    return b[2*k +: 2];
  endfunction

  task automatic step(input logic v, input logic [1:0] d);
    bus.axiiv = v;
    bus.axiid = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    rst = 1'b1;
  endtask

  task automatic expect_byte(input string name, input logic [7:0] b);
    logic [2:0] ev;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ev = (i < 4) ? {1'b1, dib(b, i)} : 3'b000;
      total++;
      if ({bus.order_axiov, bus.order_axiod} !== ev) begin
        bad++;
        $display("FAIL %s cycle %0d: got v/d=%b want %b", name, i, {bus.order_axiov, bus.order_axiod}, ev);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_stream(input string name, input logic [7:0] q[$]);
    int n;
    logic [31:0] fcs;
    logic [2:0] ev;
    logic cv;
    n = q.size();
    fcs = wire_fcs(std_crc(q));
    for (int t = 0; t < 4*n + 6; t++) begin
      bus.axiiv = 1'b0;
      bus.axiid = 2'b00;
      if (t < 4*n) begin
        bus.axiiv = 1'b1;
        bus.axiid = dib(q[t/4], 3 - t%4);
      end
      @(negedge clk);
      ev = 3'b000;
      if (t >= 4 && t < 4*n + 4) ev = {1'b1, dib(q[(t-4)/4], (t-4)%4)};
      cv = (t >= 5 && t <= 4*n + 4);
      total++;
      if ({bus.order_axiov, bus.order_axiod} !== ev) begin
        bad++;
        $display("FAIL %s order cycle %0d: got v/d=%b want %b", name, t, {bus.order_axiov, bus.order_axiod}, ev);
      end
      total++;
      if (bus.crc_axiov !== cv) begin
        bad++;
        $display("FAIL %s crc_axiov cycle %0d: got %b want %b", name, t, bus.crc_axiov, cv);
      end
      if (t == 4*n + 4) begin
        total++;
        if (bus.crc_axiod !== fcs) begin
          bad++;
          $display("FAIL %s crc_axiod: got %h want %h", name, bus.crc_axiod, fcs);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step(1'($urandom_range(0, 1)), 2'($urandom));
    bus.axiiv = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.order_axiov, bus.order_axiod, bus.crc_axiov} !== 4'b0000) begin
      bad++;
      $display("FAIL reset outputs: got v/d/cv=%b want 0000", {bus.order_axiov, bus.order_axiod, bus.crc_axiov});
    end
    total++;
    if (bus.crc_axiod !== 32'h0) begin
      bad++;
      $display("FAIL reset crc_axiod: got %h want 00000000", bus.crc_axiod);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_single_byte();
    apply_reset();
    for (int k = 3; k >= 0; k--) step(1'b1, dib(8'h31, k));
    bus.axiiv = 1'b0;
    expect_byte("single_byte", 8'h31);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    run_stream("back_to_back", '{8'hA5, 8'h3C});
  endtask

  task automatic test_check_vector();
    apply_reset();
    run_stream("check_vector", check_str);
    @(negedge clk);
    total++;
    if (bus.crc_axiod !== 32'h986C1FE3 || bus.crc_axiov !== 1'b0) begin
      bad++;
      $display("FAIL check_vector hold: got %h/%b want 986c1fe3/0", bus.crc_axiod, bus.crc_axiov);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_gaps();
    apply_reset();
    for (int k = 3; k >= 0; k--) begin
      step(1'b1, dib(8'h31, k));
      if (k > 0) repeat (3) step(1'b0, 2'($urandom));
    end
    bus.axiiv = 1'b0;
    expect_byte("gaps", 8'h31);
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    step(1'b1, 2'b11);
    step(1'b1, 2'b01);
    rst = 1'b0;
    step(1'($urandom_range(0, 1)), 2'($urandom));
    rst = 1'b1;
    run_stream("reset_midframe", check_str);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [7:0] q[$];
      int n, tail;
      q = {};
      n = $urandom_range(1, 6);
      tail = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      apply_reset();
      got = {};
      nz = 0;
      collect = 1'b1;
      for (int i = 0; i < 4*n + tail; i++) begin
        while ($urandom_range(0, 2) == 0) step(1'b0, 2'($urandom));
        step(1'b1, (i < 4*n) ? dib(q[i/4 < n ? i/4 : 0], 3 - i%4) : 2'($urandom));
      end
      repeat (8) step(1'b0, 2'($urandom));
      collect = 1'b0;
      total++;
      if (got.size() != 4*n) begin
        bad++;
        $display("FAIL random[%0d] count: got %0d want %0d", it, got.size(), 4*n);
      end else begin
        for (int i = 0; i < 4*n; i++) begin
          total++;
          if (got[i] !== dib(q[i/4], i%4)) begin
            bad++;
            $display("FAIL random[%0d] dibit %0d: got %b want %b", it, i, got[i], dib(q[i/4], i%4));
          end
        end
      end
      total++;
      if (nz != 0) begin
        bad++;
        $display("FAIL random[%0d] idle data: got %0d nonzero want 0", it, nz);
      end
      total++;
      if (bus.crc_axiod !== wire_fcs(std_crc(q)) || bus.crc_axiov !== 1'b0) begin
        bad++;
        $display("FAIL random[%0d] crc: got %h/%b want %h/0", it, bus.crc_axiod, bus.crc_axiov, wire_fcs(std_crc(q)));
      end
    end
  endtask

  initial begin
    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_check_vector();
    test_gaps();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
